step_sequencer: RTL and testbench

STEP_SEQUENCER -- requirements
Module: step_sequencer

---
 rtl/stepper_pkg.sv | 19 +
 rtl/step_timer.sv | 54 +++++
 rtl/step_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_step_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared types and default constants for the step sequencer.
package stepper_pkg;

    localparam int unsigned CNT_W_DEF        = 24;
    localparam int unsigned PER_W_DEF        = 16;
    localparam int unsigned START_PERIOD_DEF = 25000;
    localparam int unsigned RAMP_DEC_DEF     = 250;
    localparam int unsigned PULSE_W_DEF      = 50;
    localparam int unsigned DIR_SETUP_DEF    = 25;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCEL,
        ST_CRUISE,
        ST_DECEL
    } state_e;

endpackage

// File: rtl/step_timer.sv
// Times one step period: step pulse of PULSE_W cycles, then an end-of-period strobe
// during the last cycle of the period so the next step can start back-to-back.
module step_timer #(
    parameter int unsigned PER_W   = 16,
    parameter int unsigned PULSE_W = 50
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [PER_W-1:0] period_i,
    output logic             step_o,
    output logic             eop_c_o
);

    localparam logic [PER_W-1:0] PULSE_LEN = PER_W'(PULSE_W);

    logic [PER_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             step_q, step_d;
    logic             eop_c;

    // cnt_q holds the 1-based cycle index within the current period
    always_comb begin
        cnt_d  = cnt_q;
        run_d  = run_q;
        step_d = 1'b0;
        eop_c  = run_q && (cnt_q == period_i);
        if (start_i) begin
            cnt_d  = PER_W'(1);
            run_d  = 1'b1;
            step_d = 1'b1;
        end else if (run_q) begin
            cnt_d  = cnt_q + PER_W'(1);
            run_d  = ~eop_c;
            step_d = (cnt_q < PULSE_LEN);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            run_q  <= 1'b0;
            step_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            step_q <= step_d;
        end
    end

    assign step_o  = step_q;
    assign eop_c_o = eop_c;

endmodule

// File: rtl/step_sequencer.sv
// Trapezoidal stepper move sequencer: accepts a move command, ramps the step period
// from START_PERIOD down to the cruise period and back, and tracks signed position.
module step_sequencer
    import stepper_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned PER_W        = PER_W_DEF,
    parameter int unsigned START_PERIOD = START_PERIOD_DEF,
    parameter int unsigned RAMP_DEC     = RAMP_DEC_DEF,
    parameter int unsigned PULSE_W      = PULSE_W_DEF,
    parameter int unsigned DIR_SETUP    = DIR_SETUP_DEF
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             cmd_valid_in,
    output logic             cmd_ready_out,
    input  logic [CNT_W-1:0] cmd_steps_in,
    input  logic             cmd_dir_in,
    input  logic [PER_W-1:0] cmd_period_in,
    input  logic             abort_in,
    input  logic             driver_ready_in,
    output logic             step_out,
    output logic             dir_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [CNT_W-1:0] position_out
);

    localparam logic [PER_W-1:0] START_P    = PER_W'(START_PERIOD);
    localparam logic [PER_W-1:0] DEC_P      = PER_W'(RAMP_DEC);
    localparam logic [PER_W-1:0] MIN_P      = PER_W'(2 * PULSE_W);
    localparam logic [PER_W-1:0] SETUP_LAST = PER_W'(DIR_SETUP - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] ramp_cnt_q, ramp_cnt_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [PER_W-1:0] cruise_q, cruise_d;
    logic [PER_W-1:0] setup_q, setup_d;
    logic [CNT_W-1:0] position_q, position_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             cmd_ready_c;
    logic             abort_c;
    logic             decel_c;
    logic             start_c;
    logic             eop_c;
    logic [CNT_W-1:0] rem_eff_c;
    logic [PER_W:0]   inc_sum_c;
    logic [PER_W-1:0] period_inc_c;
    logic [PER_W-1:0] period_dec_c;

    assign cmd_ready_c = (state_q == ST_IDLE) && driver_ready_in;

    // Ramp arithmetic done one bit wider so neither direction can wrap
    always_comb begin
        inc_sum_c    = {1'b0, period_q} + {1'b0, DEC_P};
        period_inc_c = (inc_sum_c >= {1'b0, START_P}) ? START_P : inc_sum_c[PER_W-1:0];
        period_dec_c = ({1'b0, period_q} >= ({1'b0, cruise_q} + {1'b0, DEC_P}))
                       ? (period_q - DEC_P) : cruise_q;
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        ramp_cnt_d = ramp_cnt_q;
        period_d   = period_q;
        cruise_d   = cruise_q;
        setup_d    = setup_q;
        dir_d      = dir_q;
        position_d = position_q;
        done_d     = 1'b0;
        start_c    = 1'b0;
        abort_c    = (abort_in || !driver_ready_in) &&
                     ((state_q == ST_ACCEL) || (state_q == ST_CRUISE));
        decel_c    = (state_q == ST_DECEL) || abort_c;
        rem_eff_c  = abort_c ? ramp_cnt_q : rem_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_in && cmd_ready_c) begin
                    dir_d      = cmd_dir_in;
                    cruise_d   = (cmd_period_in < MIN_P) ? MIN_P : cmd_period_in;
                    rem_d      = cmd_steps_in;
                    ramp_cnt_d = '0;
                    setup_d    = '0;
                    if (cmd_steps_in == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (abort_in || !driver_ready_in) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (setup_q == SETUP_LAST) begin
                    start_c = 1'b1;
                    rem_d   = rem_q - CNT_W'(1);
                    if (cruise_q >= START_P) begin
                        state_d  = ST_CRUISE;
                        period_d = cruise_q;
                    end else begin
                        state_d  = ST_ACCEL;
                        period_d = START_P;
                    end
                end else begin
                    setup_d = setup_q + PER_W'(1);
                end
            end
            ST_ACCEL, ST_CRUISE, ST_DECEL: begin
                // A stop keeps the current pulse and replays the ramp in reverse
                if (abort_c) begin
                    rem_d   = ramp_cnt_q;
                    state_d = ST_DECEL;
                end
                if (eop_c) begin
                    if (rem_eff_c == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        start_c = 1'b1;
                        rem_d   = rem_eff_c - CNT_W'(1);
                        if (decel_c || (rem_eff_c <= ramp_cnt_q)) begin
                            state_d  = ST_DECEL;
                            period_d = period_inc_c;
                        end else if (state_q == ST_ACCEL) begin
                            period_d   = period_dec_c;
                            ramp_cnt_d = ramp_cnt_q + CNT_W'(1);
                            if (period_dec_c == cruise_q) begin
                                state_d = ST_CRUISE;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_c) begin
            position_d = position_q + (dir_q ? CNT_W'(1) : {CNT_W{1'b1}});
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            ramp_cnt_q <= '0;
            period_q   <= '0;
            cruise_q   <= '0;
            setup_q    <= '0;
            dir_q      <= 1'b0;
            position_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            ramp_cnt_q <= ramp_cnt_d;
            period_q   <= period_d;
            cruise_q   <= cruise_d;
            setup_q    <= setup_d;
            dir_q      <= dir_d;
            position_q <= position_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    step_timer #(
        .PER_W   (PER_W),
        .PULSE_W (PULSE_W)
    ) u_timer (
        .clk_i    (clk_in),
        .rst_i    (reset_in),
        .start_i  (start_c),
        .period_i (period_q),
        .step_o   (step_out),
        .eop_c_o  (eop_c)
    );

    assign cmd_ready_out = cmd_ready_c;
    assign dir_out       = dir_q;
    assign busy_out      = busy_q;
    assign done_out      = done_q;
    assign position_out  = position_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer with a short ramp (START 100, DEC 20, PULSE 4, SETUP 2).
module tb_step_sequencer;

    logic        clk_in;
    logic        reset_in;
    logic        cmd_valid_in;
    logic        cmd_ready_out;
    logic [23:0] cmd_steps_in;
    logic        cmd_dir_in;
    logic [15:0] cmd_period_in;
    logic        abort_in;
    logic        driver_ready_in;
    logic        step_out;
    logic        dir_out;
    logic        busy_out;
    logic        done_out;
    logic [23:0] position_out;

    int n_checks = 0;
    int n_fail   = 0;

    int rise_t[$];
    int done_t;
    int n_done;
    int hi_min;
    int hi_max;
    bit busy_seen;
    bit dir_seen;
    int exp_a[12];

    step_sequencer #(
        .CNT_W        (24),
        .PER_W        (16),
        .START_PERIOD (100),
        .RAMP_DEC     (20),
        .PULSE_W      (4),
        .DIR_SETUP    (2)
    ) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .cmd_valid_in    (cmd_valid_in),
        .cmd_ready_out   (cmd_ready_out),
        .cmd_steps_in    (cmd_steps_in),
        .cmd_dir_in      (cmd_dir_in),
        .cmd_period_in   (cmd_period_in),
        .abort_in        (abort_in),
        .driver_ready_in (driver_ready_in),
        .step_out        (step_out),
        .dir_out         (dir_out),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .position_out    (position_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Periods are rise-to-rise; the last one runs from its rise to done_out
    task automatic check_periods(input string tag, input int n, input int exp[12]);
        int got;
        check({tag, "_nsteps"}, 32'(rise_t.size()), 32'(n));
        for (int i = 0; i < n && i < rise_t.size(); i++) begin
            got = (i + 1 < rise_t.size()) ? rise_t[i+1] - rise_t[i] : done_t - rise_t[i];
            check($sformatf("%s_per%0d", tag, i), 32'(got), 32'(exp[i]));
        end
        check({tag, "_done_cnt"}, 32'(n_done), 1);
    endtask

    task automatic run_move(input int steps, input bit dir, input int per,
                            input int abort_at, input int drop_at);
        bit prev;
        int hi;
        bit aborted;
        prev = 1'b0;
        hi = 0;
        aborted = 1'b0;
        rise_t.delete();
        done_t = -1;
        n_done = 0;
        hi_min = 1000;
        hi_max = 0;
        busy_seen = 1'b0;
        dir_seen = 1'b0;
        check("cmd_ready_idle", 32'(cmd_ready_out), 1);
        cmd_steps_in  = 24'(steps);
        cmd_dir_in    = dir;
        cmd_period_in = 16'(per);
        cmd_valid_in  = 1'b1;
        @(negedge clk_in);
        cmd_valid_in = 1'b0;
        for (int t = 1; t < 3000; t++) begin
            if (step_out && !prev) begin
                rise_t.push_back(t);
                hi = 0;
            end
            if (step_out) begin
                hi++;
            end else if (prev) begin
                if (hi < hi_min) hi_min = hi;
                if (hi > hi_max) hi_max = hi;
            end
            prev = step_out;
            if (busy_out) busy_seen = 1'b1;
            if (t == 1) dir_seen = dir_out;
            if (done_out) begin
                n_done++;
                if (done_t < 0) done_t = t;
            end
            if (done_t >= 0 && t >= done_t + 3) break;
            abort_in = 1'b0;
            if (abort_at >= 0 && !aborted && rise_t.size() == abort_at) begin
                abort_in = 1'b1;
                aborted  = 1'b1;
            end
            if (drop_at >= 0 && rise_t.size() >= drop_at) driver_ready_in = 1'b0;
            @(negedge clk_in);
        end
        abort_in = 1'b0;
    endtask

    initial begin
        cmd_valid_in    = 1'b0;
        cmd_steps_in    = '0;
        cmd_dir_in      = 1'b0;
        cmd_period_in   = '0;
        abort_in        = 1'b0;
        driver_ready_in = 1'b1;
        reset_in        = 1'b1;
        #1;
        check("rst_step", 32'(step_out), 0);
        check("rst_busy", 32'(busy_out), 0);
        check("rst_done", 32'(done_out), 0);
        check("rst_pos", 32'(position_out), 0);
        @(negedge clk_in);
        reset_in = 1'b0;
        @(negedge clk_in);

        // Full trapezoid
        run_move(10, 1'b1, 40, -1, -1);
        exp_a = '{100, 80, 60, 40, 40, 40, 40, 60, 80, 100, 0, 0};
        check_periods("trap", 10, exp_a);
        check("trap_first_rise", 32'(rise_t.size() > 0 ? rise_t[0] : -1), 3);
        check("trap_dir", 32'(dir_seen), 1);
        check("trap_pos", 32'(position_out), 10);
        check("trap_hi_min", 32'(hi_min), 4);
        check("trap_hi_max", 32'(hi_max), 4);
        check("trap_idle", 32'(busy_out), 0);

        // Short move, ramp never reaches cruise
        run_move(3, 1'b1, 40, -1, -1);
        exp_a = '{100, 80, 100, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_periods("short", 3, exp_a);
        check("short_pos", 32'(position_out), 13);

        // Zero-step move
        run_move(0, 1'b1, 40, -1, -1);
        check("zero_done_t", 32'(done_t), 1);
        check("zero_done_cnt", 32'(n_done), 1);
        check("zero_nsteps", 32'(rise_t.size()), 0);
        check("zero_busy", 32'(busy_seen), 0);
        check("zero_pos", 32'(position_out), 13);

        // Abort while cruising at step 5
        run_move(100, 1'b1, 40, 5, -1);
        exp_a = '{100, 80, 60, 40, 40, 60, 80, 100, 0, 0, 0, 0};
        check_periods("abort", 8, exp_a);
        check("abort_pos", 32'(position_out), 21);

        // Period below 2*PULSE_W is clamped to 8, negative direction
        run_move(12, 1'b0, 2, -1, -1);
        exp_a = '{100, 80, 60, 40, 20, 8, 8, 28, 48, 68, 88, 100};
        check_periods("clamp", 12, exp_a);
        check("clamp_dir", 32'(dir_seen), 0);
        check("clamp_hi_min", 32'(hi_min), 4);
        check("clamp_hi_max", 32'(hi_max), 4);
        check("clamp_pos", 32'(position_out), 9);

        // Abort during direction setup
        run_move(5, 1'b1, 40, 0, -1);
        check("sabort_nsteps", 32'(rise_t.size()), 0);
        check("sabort_done_t", 32'(done_t), 2);
        check("sabort_done_cnt", 32'(n_done), 1);
        check("sabort_pos", 32'(position_out), 9);

        // Driver loss during step 2 acts as abort
        run_move(100, 1'b1, 40, -1, 2);
        exp_a = '{100, 80, 100, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_periods("drop", 3, exp_a);
        check("drop_pos", 32'(position_out), 12);
        check("drop_not_ready", 32'(cmd_ready_out), 0);
        driver_ready_in = 1'b1;
        @(negedge clk_in);

        // Asynchronous reset in the middle of a step pulse
        cmd_steps_in  = 24'd5;
        cmd_dir_in    = 1'b1;
        cmd_period_in = 16'd40;
        cmd_valid_in  = 1'b1;
        @(negedge clk_in);
        cmd_valid_in = 1'b0;
        for (int i = 0; i < 50 && !step_out; i++) @(negedge clk_in);
        check("mid_step_high", 32'(step_out), 1);
        #2;
        reset_in = 1'b1;
        #1;
        check("mid_rst_step", 32'(step_out), 0);
        check("mid_rst_pos", 32'(position_out), 0);
        check("mid_rst_busy", 32'(busy_out), 0);
        check("mid_rst_dir", 32'(dir_out), 0);
        @(negedge clk_in);
        reset_in = 1'b0;
        @(negedge clk_in);
        check("post_rst_ready", 32'(cmd_ready_out), 1);
        driver_ready_in = 1'b0;
        #1;
        check("post_rst_not_ready", 32'(cmd_ready_out), 0);
        driver_ready_in = 1'b1;
        @(negedge clk_in);

        // Cruise at or above START_PERIOD skips the ramp; position wraps below zero
        run_move(2, 1'b0, 200, -1, -1);
        exp_a = '{200, 200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_periods("noramp", 2, exp_a);
        check("noramp_pos", 32'(position_out), 32'h00FF_FFFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
